// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-wide RAM port arbiter: FSM states,
// memory access length codes and a helper that maps a length code to a byte count.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle  = 2'd0,
    ArbIfRd  = 2'd1,
    ArbMemRd = 2'd2,
    ArbMemWr = 2'd3
  } arb_state_t;

  localparam int MemLenBus = 2;

  localparam logic [MemLenBus-1:0] MemLen1 = 2'd0;
  localparam logic [MemLenBus-1:0] MemLen2 = 2'd1;
  localparam logic [MemLenBus-1:0] MemLen4 = 2'd2;

  // The reserved code 3 falls into the default and moves a full word.
  function automatic logic [2:0] len_bytes(input logic [MemLenBus-1:0] len);
    case (len)
      MemLen1: return 3'd1;
      MemLen2: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single byte-wide synchronous RAM port between instruction fetch
// and load/store, sequencing each request as a multi-cycle byte transfer.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [ADDR_W-1:0]    if_addr,
  input  logic                 if_flush,
  output logic                 if_done,
  output logic [31:0]          if_data,
  input  logic                 mem_req,
  input  logic                 mem_we,
  input  logic [MemLenBus-1:0] mem_len,
  input  logic [ADDR_W-1:0]    mem_addr,
  input  logic [31:0]          mem_wdata,
  output logic                 mem_done,
  output logic [31:0]          mem_rdata,
  output logic [ADDR_W-1:0]    ram_a,
  output logic                 ram_we,
  output logic [7:0]           ram_dout,
  input  logic [7:0]           ram_din,
  output logic                 busy
);

  arb_state_t        state_reg, state_next;
  logic [2:0]        cnt_reg, cnt_next;
  logic [2:0]        n_reg, n_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic [31:0]       wbuf_reg, wbuf_next;
  logic [31:0]       asm_reg, asm_next;
  logic [ADDR_W-1:0] ram_a_reg, ram_a_next;
  logic              ram_we_reg, ram_we_next;
  logic [7:0]        ram_dout_reg, ram_dout_next;
  logic              if_done_reg, if_done_next;
  logic              mem_done_reg, mem_done_next;
  logic [31:0]       if_data_reg, if_data_next;
  logic [31:0]       mem_rdata_reg, mem_rdata_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ArbIdle;
      cnt_reg       <= '0;
      n_reg         <= '0;
      base_reg      <= '0;
      wbuf_reg      <= '0;
      asm_reg       <= '0;
      ram_a_reg     <= '0;
      ram_we_reg    <= 1'b0;
      ram_dout_reg  <= '0;
      if_done_reg   <= 1'b0;
      mem_done_reg  <= 1'b0;
      if_data_reg   <= '0;
      mem_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      n_reg         <= n_next;
      base_reg      <= base_next;
      wbuf_reg      <= wbuf_next;
      asm_reg       <= asm_next;
      ram_a_reg     <= ram_a_next;
      ram_we_reg    <= ram_we_next;
      ram_dout_reg  <= ram_dout_next;
      if_done_reg   <= if_done_next;
      mem_done_reg  <= mem_done_next;
      if_data_reg   <= if_data_next;
      mem_rdata_reg <= mem_rdata_next;
    end
  end

  // cnt_reg is the index of the edge being processed; byte k arrives two edges after its address.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    n_next         = n_reg;
    base_next      = base_reg;
    wbuf_next      = wbuf_reg;
    asm_next       = asm_reg;
    ram_a_next     = ram_a_reg;
    ram_we_next    = 1'b0;
    ram_dout_next  = ram_dout_reg;
    if_done_next   = 1'b0;
    mem_done_next  = 1'b0;
    if_data_next   = if_data_reg;
    mem_rdata_next = mem_rdata_reg;

    case (state_reg)
      ArbIdle: begin
        if (mem_req && !mem_done_reg) begin
          state_next = mem_we ? ArbMemWr : ArbMemRd;
          base_next  = mem_addr;
          n_next     = len_bytes(mem_len);
          cnt_next   = 3'd1;
          asm_next   = '0;
          ram_a_next = mem_addr;
          if (mem_we) begin
            ram_we_next   = 1'b1;
            ram_dout_next = mem_wdata[7:0];
            wbuf_next     = mem_wdata >> 8;
          end
        end else if (if_req && !if_flush && !if_done_reg) begin
          state_next = ArbIfRd;
          base_next  = if_addr;
          n_next     = 3'd4;
          cnt_next   = 3'd1;
          asm_next   = '0;
          ram_a_next = if_addr;
        end
      end

      ArbIfRd, ArbMemRd: begin
        if (state_reg == ArbIfRd && if_flush) begin
          state_next = ArbIdle;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 3'd1;
          if (cnt_reg < n_reg)
            ram_a_next = base_reg + ADDR_W'(cnt_reg);
          for (int b = 0; b < 4; b++)
            if (cnt_reg == 3'(b + 2))
              asm_next[8*b +: 8] = ram_din;
          if (cnt_reg == n_reg + 3'd1) begin
            state_next = ArbIdle;
            cnt_next   = '0;
            if (state_reg == ArbIfRd) begin
              if_done_next = 1'b1;
              if_data_next = asm_next;
            end else begin
              mem_done_next  = 1'b1;
              mem_rdata_next = asm_next;
            end
          end
        end
      end

      ArbMemWr: begin
        if (cnt_reg < n_reg) begin
          ram_a_next    = base_reg + ADDR_W'(cnt_reg);
          ram_we_next   = 1'b1;
          ram_dout_next = wbuf_reg[7:0];
          wbuf_next     = wbuf_reg >> 8;
          cnt_next      = cnt_reg + 3'd1;
        end else begin
          state_next    = ArbIdle;
          cnt_next      = '0;
          mem_done_next = 1'b1;
        end
      end

      default: state_next = ArbIdle;
    endcase
  end

  assign if_done   = if_done_reg;
  assign if_data   = if_data_reg;
  assign mem_done  = mem_done_reg;
  assign mem_rdata = mem_rdata_reg;
  assign ram_a     = ram_a_reg;
  assign ram_we    = ram_we_reg;
  assign ram_dout  = ram_dout_reg;
  assign busy      = (state_reg != ArbIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a synchronous byte RAM, a transaction-level model of the
// arbiter checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_mem_arbiter;

  localparam int K_IF = 0;
  localparam int K_RD = 1;
  localparam int K_WR = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic        if_done;
  logic [31:0] if_data;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [1:0]  mem_len = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [31:0] ram_a;
  logic        ram_we;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = '0;
  logic        busy;

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_a(ram_a), .ram_we(ram_we), .ram_dout(ram_dout), .ram_din(ram_din),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
  endfunction

  // RAM seen by the DUT, and the model's own image of what memory should hold
  logic [7:0] ram_mem   [logic [31:0]];
  logic [7:0] model_mem [logic [31:0]];

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] mdl_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_byte(a);
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    ram_mem[a]   = d;
    model_mem[a] = d;
  endtask

  initial forever begin
    @(posedge clk);
    if (ram_we) ram_mem[ram_a] = ram_dout;
    ram_din <= ram_rd(ram_a);
  end

  // Transaction-level model: expected port/output values after each edge
  logic [31:0] exp_a = '0, exp_if_data = '0, exp_mem_rdata = '0;
  logic [7:0]  exp_dout = '0;
  logic        exp_we = 1'b0, exp_if_done = 1'b0, exp_mem_done = 1'b0;
  bit          m_act = 1'b0;
  int          m_kind = K_IF, m_n = 0, m_start = 0, cyc = 0;
  logic [31:0] m_base = '0, m_wdata = '0, m_word = '0;

  initial forever begin
    logic pif, pmd;
    int k;
    @(posedge clk);
    if (exp_we) model_mem[exp_a] = exp_dout;
    cyc++;
    pif = exp_if_done;
    pmd = exp_mem_done;
    exp_if_done  = 1'b0;
    exp_mem_done = 1'b0;
    if (rst) begin
      exp_a = '0; exp_we = 1'b0; exp_dout = '0;
      exp_if_data = '0; exp_mem_rdata = '0; m_act = 1'b0;
    end else if (!m_act) begin
      if (mem_req && !pmd) begin
        m_act = 1'b1; m_kind = mem_we ? K_WR : K_RD; m_base = mem_addr;
        m_n = (mem_len == 2'd0) ? 1 : (mem_len == 2'd1) ? 2 : 4;
        m_wdata = mem_wdata; m_start = cyc;
      end else if (if_req && !if_flush && !pif) begin
        m_act = 1'b1; m_kind = K_IF; m_base = if_addr; m_n = 4; m_start = cyc;
      end
      if (m_act) begin
        m_word = '0;
        for (int i = 0; i < m_n; i++) m_word[8*i +: 8] = mdl_rd(m_base + 32'(i));
        exp_a = m_base;
        if (m_kind == K_WR) begin
          exp_we = 1'b1;
          exp_dout = m_wdata[7:0];
        end
      end
    end else begin
      k = cyc - m_start;
      if (m_kind == K_WR) begin
        if (k < m_n) begin
          exp_a = m_base + 32'(k); exp_dout = m_wdata[8*k +: 8]; exp_we = 1'b1;
        end else begin
          exp_we = 1'b0; exp_mem_done = 1'b1; m_act = 1'b0;
        end
      end else if (m_kind == K_IF && if_flush) begin
        m_act = 1'b0;
      end else begin
        if (k < m_n) exp_a = m_base + 32'(k);
        if (k == m_n + 1) begin
          m_act = 1'b0;
          if (m_kind == K_IF) begin
            exp_if_done = 1'b1; exp_if_data = m_word;
          end else begin
            exp_mem_done = 1'b1; exp_mem_rdata = m_word;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("ram_a", ram_a, exp_a);
      chk("ram_we", 32'(ram_we), 32'(exp_we));
      chk("ram_dout", 32'(ram_dout), 32'(exp_dout));
      chk("if_done", 32'(if_done), 32'(exp_if_done));
      chk("mem_done", 32'(mem_done), 32'(exp_mem_done));
      chk("if_data", if_data, exp_if_data);
      chk("mem_rdata", mem_rdata, exp_mem_rdata);
      chk("busy", 32'(busy), 32'(m_act));
    end
  end

  // Observation helpers for the directed scenarios
  int          we_cnt = 0, if_done_cnt = 0, mem_done_cnt = 0;
  bit          trace_en = 1'b0;
  logic [31:0] trace_q[$];

  initial forever begin
    @(negedge clk);
    if (if_done === 1'b1) if_done_cnt++;
    if (mem_done === 1'b1) mem_done_cnt++;
    if (trace_en) begin
      if (ram_we === 1'b1) we_cnt++;
      if (busy === 1'b1) trace_q.push_back(ram_a);
    end
  end

  task automatic wait_done(input bit is_mem, input int max, output int n);
    n = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if ((is_mem ? mem_done : if_done) === 1'b1) begin
        n = i;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout: got no done, required done within %0d cycles", is_mem ? "mem" : "if", max);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
    return 32'h1000 + 32'($urandom_range(0, 63));
  endfunction

  initial begin
    int n, cnt0;
    repeat (3) step();
    chk_en = 1'b1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ram_a", ram_a, 32'd0);
    rst = 1'b0;

    // Word fetch
    poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
    we_cnt = 0; trace_en = 1'b1;
    if_req = 1'b1; if_addr = 32'h100;
    wait_done(1'b0, 12, n);
    chk("fetch_latency", 32'(n), 32'd7);
    chk("fetch_data", if_data, 32'h0000_0513);
    chk("fetch_no_we", 32'(we_cnt), 32'd0);
    trace_en = 1'b0;
    step();
    if_req = 1'b0;

    // Priority: load halfword beats a simultaneous fetch
    poke(32'h2000, 8'h34); poke(32'h2001, 8'h12);
    poke(32'h104, 8'h93); poke(32'h105, 8'h02); poke(32'h106, 8'h10); poke(32'h107, 8'h00);
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd1; mem_addr = 32'h2000;
    if_req = 1'b1; if_addr = 32'h104;
    wait_done(1'b1, 12, n);
    chk("prio_latency", 32'(n), 32'd5);
    chk("prio_rdata", mem_rdata, 32'h0000_1234);
    chk("prio_no_if_done", 32'(if_done), 32'd0);
    step();
    mem_req = 1'b0;
    chk("prio_fetch_follows", 32'(busy), 32'd1);
    wait_done(1'b0, 12, n);
    chk("prio_fetch_data", if_data, 32'h0010_0293);
    step();
    if_req = 1'b0;

    // Store word
    we_cnt = 0; trace_en = 1'b1;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd2; mem_addr = 32'h3000; mem_wdata = 32'hDEAD_BEEF;
    wait_done(1'b1, 12, n);
    chk("store_latency", 32'(n), 32'd6);
    chk("store_we_cycles", 32'(we_cnt), 32'd4);
    trace_en = 1'b0;
    step();
    mem_req = 1'b0;
    chk("store_we_off", 32'(ram_we), 32'd0);
    chk("store_b0", 32'(ram_rd(32'h3000)), 32'hEF);
    chk("store_b1", 32'(ram_rd(32'h3001)), 32'hBE);
    chk("store_b2", 32'(ram_rd(32'h3002)), 32'hAD);
    chk("store_b3", 32'(ram_rd(32'h3003)), 32'hDE);

    // Flush two cycles into a fetch, then refetch at the jump target
    poke(32'h200, 8'h78); poke(32'h201, 8'h56); poke(32'h202, 8'h34); poke(32'h203, 8'h12);
    cnt0 = if_done_cnt;
    if_req = 1'b1; if_addr = 32'h100;
    step(); step();
    if_flush = 1'b1;
    step();
    if_flush = 1'b0;
    chk("flush_idle", 32'(busy), 32'd0);
    if_addr = 32'h200;
    wait_done(1'b0, 12, n);
    chk("flush_refetch_latency", 32'(n), 32'd7);
    chk("flush_refetch_data", if_data, 32'h1234_5678);
    chk("flush_single_done", 32'(if_done_cnt - cnt0), 32'd1);
    step();
    if_req = 1'b0;

    // Address wrap on a word load
    poke(32'hFFFF_FFFE, 8'h11); poke(32'hFFFF_FFFF, 8'h22); poke(32'h0, 8'h33); poke(32'h1, 8'h44);
    trace_q.delete(); trace_en = 1'b1;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd2; mem_addr = 32'hFFFF_FFFE;
    wait_done(1'b1, 12, n);
    trace_en = 1'b0;
    chk("wrap_rdata", mem_rdata, 32'h4433_2211);
    chk("wrap_trace_len", 32'(trace_q.size() >= 4), 32'd1);
    if (trace_q.size() >= 4) begin
      chk("wrap_a0", trace_q[0], 32'hFFFF_FFFE);
      chk("wrap_a1", trace_q[1], 32'hFFFF_FFFF);
      chk("wrap_a2", trace_q[2], 32'h0000_0000);
      chk("wrap_a3", trace_q[3], 32'h0000_0001);
    end
    step();
    mem_req = 1'b0;

    // Reset in the middle of a store, after two bytes
    cnt0 = mem_done_cnt;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd2; mem_addr = 32'h4000; mem_wdata = 32'hA1B2_C3D4;
    step(); step();
    rst = 1'b1; mem_req = 1'b0;
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_ram_a", ram_a, 32'd0);
    chk("rst_dout", 32'(ram_dout), 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    rst = 1'b0;
    repeat (4) step();
    chk("rst_no_done", 32'(mem_done_cnt - cnt0), 32'd0);
    chk("rst_partial_b0", 32'(ram_rd(32'h4000)), 32'hD4);
    chk("rst_partial_b1", 32'(ram_rd(32'h4001)), 32'hC3);
    chk("rst_partial_b2", 32'(ram_rd(32'h4002)), 32'(init_byte(32'h4002)));

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      step();
      rst = ($urandom_range(0, 399) == 0);
      if_flush = 1'b0;
      if (if_done) begin
        if_req = 1'($urandom_range(0, 1));
        if_addr = rand_addr();
      end else if (!if_req) begin
        if ($urandom_range(0, 2) == 0) begin
          if_req = 1'b1;
          if_addr = rand_addr();
        end
      end else if ($urandom_range(0, 11) == 0) begin
        if_flush = 1'b1;
        if_addr = rand_addr();
      end else if (m_act && m_kind == K_IF) begin
        if_addr = $urandom();
      end
      if (mem_done || !mem_req) begin
        mem_req = ($urandom_range(0, 2) == 0);
        mem_we = 1'($urandom_range(0, 1));
        mem_len = 2'($urandom_range(0, 3));
        mem_addr = rand_addr();
        mem_wdata = $urandom();
      end else if (m_act && m_kind != K_IF) begin
        mem_we = 1'($urandom_range(0, 1));
        mem_len = 2'($urandom_range(0, 3));
        mem_addr = $urandom();
        mem_wdata = $urandom();
      end
    end
    rst = 1'b0; if_req = 1'b0; mem_req = 1'b0; if_flush = 1'b0;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
